// File: rtl/cnoc_pkg.sv
// Shared definitions for the CNOC indication path: header field layout,
// deframer state encoding and the header word type.
package cnoc_pkg;

  localparam int WORD_W         = 32;
  localparam int HDR_LEN_LSB    = 0;
  localparam int HDR_LEN_W      = 16;
  localparam int HDR_METHOD_LSB = 16;
  localparam int HDR_METHOD_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } deframe_state_t;

  // Header word as produced by the indication serializer; bits [31:24] are unused.
  typedef struct packed {
    logic [7:0]              rsvd;
    logic [HDR_METHOD_W-1:0] method;
    logic [HDR_LEN_W-1:0]    len;
  } cnoc_hdr_t;

endpackage

// File: rtl/cnoc_out_reg.sv
// One-entry valid/ready output holding register for deframed payload words.
module cnoc_out_reg
  import cnoc_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    load,
  input  logic [WORD_W-1:0]       load_data,
  input  logic [HDR_METHOD_W-1:0] load_method,
  input  logic                    load_last,
  input  logic                    out_ready,
  output logic [WORD_W-1:0]       out_data,
  output logic [HDR_METHOD_W-1:0] out_method,
  output logic                    out_last,
  output logic                    out_valid
);

  // The caller only asserts load when the slot is empty or being drained this cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_data   <= '0;
      out_method <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
    end else if (load) begin
      out_data   <= load_data;
      out_method <= load_method;
      out_last   <= load_last;
      out_valid  <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/cnoc_ind_deframer.sv
// Splits the upstream indication word stream into header + payload messages.
// Optional saturating error counter enabled by CNOC_DEFRAME_ERRCNT_EN.
//
// state   | meaning
// IDLE    | next upstream word is a header
// PAYLOAD | forwarding payload words of an accepted message
// DRAIN   | discarding payload words of an oversize message
module cnoc_ind_deframer
  import cnoc_pkg::*;
#(
  parameter int MAX_PAYLOAD = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] ind_first,
  input  logic        ind_rdy,
  output logic        EN_ind_deq,
  output logic [31:0] out_data,
  output logic [7:0]  out_method,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err,
  output logic [15:0] msg_count,
  output logic [7:0]  err_count
);

  localparam logic [HDR_LEN_W-1:0] LEN_MAX = HDR_LEN_W'(MAX_PAYLOAD + 1);

  deframe_state_t          state;
  logic [15:0]             remaining;
  logic [HDR_METHOD_W-1:0] method_q;
  logic [HDR_LEN_W-1:0]    hdr_len;
  logic [HDR_METHOD_W-1:0] hdr_method;
  logic                    load;

  assign hdr_len    = ind_first[HDR_LEN_LSB +: HDR_LEN_W];
  assign hdr_method = ind_first[HDR_METHOD_LSB +: HDR_METHOD_W];

  always_comb begin
    EN_ind_deq = 1'b0;
    case (state)
      ST_IDLE:    EN_ind_deq = ind_rdy;
      ST_PAYLOAD: EN_ind_deq = ind_rdy && (!out_valid || out_ready);
      ST_DRAIN:   EN_ind_deq = ind_rdy;
      default:    EN_ind_deq = 1'b0;
    endcase
  end

  assign load = (state == ST_PAYLOAD) && EN_ind_deq;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      remaining <= '0;
      method_q  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ind_rdy) begin
            remaining <= hdr_len - 16'd1;
            method_q  <= hdr_method;
            if (hdr_len <= 16'd1) begin
              frame_err <= 1'b1;
            end else if (hdr_len > LEN_MAX) begin
              frame_err <= 1'b1;
              state     <= ST_DRAIN;
            end else begin
              state     <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD, ST_DRAIN: begin
          if (EN_ind_deq) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      msg_count <= '0;
    end else if (out_valid && out_ready && out_last) begin
      msg_count <= msg_count + 16'd1;
    end
  end

`ifdef CNOC_DEFRAME_ERRCNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_count <= '0;
    end else if (frame_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = '0;
`endif

  cnoc_out_reg u_out_reg (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .load        (load),
    .load_data   (ind_first),
    .load_method (method_q),
    .load_last   (remaining == 16'd1),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_method  (out_method),
    .out_last    (out_last),
    .out_valid   (out_valid)
  );

endmodule

// File: tb/tb_cnoc_ind_deframer.sv
// Scoreboard bench for cnoc_ind_deframer: upstream FIFO model plus message-level reference.
module tb_cnoc_ind_deframer;

  localparam int MAXP = 16;
  localparam int K_HDR_OK  = 0;
  localparam int K_HDR_BAD = 1;
  localparam int K_PAY     = 2;
  localparam int K_DROP    = 3;

  typedef struct {
    logic [31:0] word;
    int          kind;
  } up_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  method;
    logic        last;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] ind_first = '0;
  logic        ind_rdy = 1'b0;
  logic        out_ready = 1'b0;
  logic        EN_ind_deq;
  logic [31:0] out_data;
  logic [7:0]  out_method;
  logic        out_last;
  logic        out_valid;
  logic        frame_err;
  logic [15:0] msg_count;
  logic [7:0]  err_count;

  up_t  up_q[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_pct = 100;
  int   ready_pct = 100;
  int   stall = 0;
  bit   pop_seen = 1'b0;
  int   exp_msgs = 0;
  int   exp_errs = 0;

  cnoc_ind_deframer #(.MAX_PAYLOAD(MAXP)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ind_first  (ind_first),
    .ind_rdy    (ind_rdy),
    .EN_ind_deq (EN_ind_deq),
    .out_data   (out_data),
    .out_method (out_method),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .msg_count  (msg_count),
    .err_count  (err_count)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a message is good when 2 <= len <= MAXP+1; len<=1 consumes only the
  // header, oversize headers swallow len-1 following words.
  task automatic push_msg(input logic [31:0] hdr, input logic [31:0] base, input bit fixed);
    up_t  u;
    exp_t e;
    int   len;
    bit   bad;
    len = int'(hdr[15:0]);
    bad = (len <= 1) || (len > MAXP + 1);
    u.word = hdr;
    u.kind = bad ? K_HDR_BAD : K_HDR_OK;
    up_q.push_back(u);
    if (bad) exp_errs++;
    else exp_msgs++;
    for (int i = 1; i < len; i++) begin
      u.word = fixed ? base + 32'(i) : $urandom;
      u.kind = bad ? K_DROP : K_PAY;
      up_q.push_back(u);
      if (!bad) begin
        e.data   = u.word;
        e.method = hdr[23:16];
        e.last   = (i == len - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (pop_seen && up_q.size() > 0) void'(up_q.pop_front());
    ind_rdy   = (up_q.size() > 0) && ($urandom_range(0, 99) < rdy_pct);
    ind_first = ind_rdy ? up_q[0].word : $urandom;
    if (stall > 0) begin
      out_ready = 1'b0;
      stall--;
    end else begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((up_q.size() > 0 || exp_q.size() > 0 || out_valid) && n < 20000) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(n < 20000), 32'd1);
    tick();
    tick();
  endtask

  task automatic check_counts(input string name);
    check({name, "_msg_count"}, 32'(msg_count), 32'(exp_msgs % 65536));
`ifdef CNOC_DEFRAME_ERRCNT_EN
    check({name, "_err_count"}, 32'(err_count), 32'(exp_errs > 255 ? 255 : exp_errs));
`else
    check({name, "_err_count"}, 32'(err_count), 32'd0);
`endif
  endtask

  task automatic check_reset(input string name);
    check({name, "_valid"},  32'(out_valid), 32'd0);
    check({name, "_data"},   out_data, 32'd0);
    check({name, "_method"}, 32'(out_method), 32'd0);
    check({name, "_last"},   32'(out_last), 32'd0);
    check({name, "_ferr"},   32'(frame_err), 32'd0);
    check({name, "_msgcnt"}, 32'(msg_count), 32'd0);
    check({name, "_errcnt"}, 32'(err_count), 32'd0);
    check({name, "_deq"},    32'(EN_ind_deq), 32'd0);
  endtask

  // Monitor: samples mid-cycle, predicts EN_ind_deq and frame_err from the kind of
  // the upstream head word, and scores every output transfer.
  initial begin
    logic        prev_stall;
    logic [31:0] pd;
    logic [7:0]  pm;
    logic        pl;
    logic        ferr_exp;
    logic        exp_en;
    exp_t        e;
    prev_stall = 1'b0;
    ferr_exp   = 1'b0;
    pd = '0; pm = '0; pl = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_stall = 1'b0;
        ferr_exp   = 1'b0;
        pop_seen   = 1'b0;
        continue;
      end
      check("frame_err", 32'(frame_err), 32'(ferr_exp));
      if (prev_stall) begin
        check("hold_valid",  32'(out_valid), 32'd1);
        check("hold_data",   out_data, pd);
        check("hold_method", 32'(out_method), 32'(pm));
        check("hold_last",   32'(out_last), 32'(pl));
      end
      if (up_q.size() == 0) begin
        check("deq_empty", 32'(EN_ind_deq), 32'd0);
      end else begin
        exp_en = (up_q[0].kind == K_PAY) ? (ind_rdy && (!out_valid || out_ready)) : ind_rdy;
        check("deq", 32'(EN_ind_deq), 32'(exp_en));
      end
      ferr_exp = EN_ind_deq && (up_q.size() > 0) && (up_q[0].kind == K_HDR_BAD);
      pop_seen = EN_ind_deq;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data",   out_data, e.data);
          check("out_method", 32'(out_method), 32'(e.method));
          check("out_last",   32'(out_last), 32'(e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pm = out_method;
      pl = out_last;
    end
  end

  initial begin
    int n;
    RST_N = 1'b0;
    #2;
    check_reset("rst0");
    tick();
    tick();
    #2 RST_N = 1'b1;

    // nominal message: 0xA, 0xB on method 3
    rdy_pct = 100; ready_pct = 100;
    push_msg(32'h0003_0003, 32'h9, 1'b1);
    drain("nominal");
    check_counts("nominal");

    // backpressure: 4 payload words, 5 stalled cycles mid-message
    push_msg(32'h0005_0005, 32'h100, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check("bp_started", 32'(out_valid), 32'd1);
    stall = 5;
    drain("bp");
    check_counts("bp");

    // short headers, then a normal message
    push_msg(32'h0001_0001, 32'h0, 1'b0);
    push_msg(32'hFF07_0004, 32'h0, 1'b0);
    push_msg(32'h0022_0000, 32'h0, 1'b0);
    push_msg(32'h0009_0002, 32'h0, 1'b0);
    drain("short");
    check_counts("short");

    // oversize drain and the MAX boundary
    push_msg(32'h0004_0014, 32'h0, 1'b0);
    push_msg(32'h0005_0002, 32'h0, 1'b0);
    push_msg(32'h0006_0011, 32'h0, 1'b0);
    push_msg(32'h0007_0012, 32'h0, 1'b0);
    push_msg(32'h0008_0003, 32'h0, 1'b0);
    drain("oversize");
    check_counts("oversize");

    // back-to-back at full throughput
    for (int i = 0; i < 6; i++)
      push_msg({8'($urandom), 8'($urandom), 16'($urandom_range(2, MAXP + 1))}, 32'h0, 1'b0);
    drain("b2b");
    check_counts("b2b");

    // random traffic with random gaps and backpressure
    rdy_pct = 70; ready_pct = 60;
    for (int i = 0; i < 150; i++)
      push_msg({8'($urandom), 8'($urandom), 16'($urandom_range(0, 20))}, 32'h0, 1'b0);
    drain("random");
    check_counts("random");

    // reset in the middle of a payload
    rdy_pct = 100; ready_pct = 100;
    push_msg(32'h0011_0009, 32'h0, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    tick();
    tick();
    #2;
    RST_N   = 1'b0;
    ind_rdy = 1'b0;
    up_q.delete();
    exp_q.delete();
    exp_msgs = 0;
    exp_errs = 0;
    #1;
    check_reset("rst_mid");
    tick();
    tick();
    #2 RST_N = 1'b1;
    push_msg(32'h0042_0003, 32'h50, 1'b1);
    drain("post_rst");
    check_counts("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnoc_ind_deframer.md
CNOC_IND_DEFRAMER -- requirements
Module: cnoc_ind_deframer

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 16, the largest accepted payload word count (1..4095).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ind_first, input, 32, the head word of the upstream indication message FIFO.
REQ-005 SHALL have port ind_rdy, input, 1, high when ind_first is valid (upstream FIFO not empty).
REQ-006 SHALL have port EN_ind_deq, output, 1, pops one upstream word in the cycle it is high.
REQ-007 SHALL have port out_data, output, 32, the payload word.
REQ-008 SHALL have port out_method, output, 8, the method number of the message the word belongs to.
REQ-009 SHALL have port out_last, output, 1, marks the final payload word of a message.
REQ-010 SHALL have port out_valid, output, 1, high when the out_* fields hold a word.
REQ-011 SHALL have port out_ready, input, 1, downstream accept; a transfer occurs when out_valid and out_ready are both high.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on a rejected header.
REQ-013 SHALL have port msg_count, output, 16, count of messages fully delivered; wraps from 0xFFFF to 0.
REQ-014 SHALL have port err_count, output, 8, count of framing errors (see REQ-027).

Function
REQ-015 Header word format SHALL be: method = ind_first[23:16]; len = ind_first[15:0], where len is the total word count including the header. Bits [31:24] are ignored.
REQ-016 The FSM SHALL have states IDLE, PAYLOAD and DRAIN; the reset state is IDLE.
REQ-017 In IDLE, EN_ind_deq SHALL equal ind_rdy, consuming the header.
REQ-018 On header consumption, the block SHALL set remaining = len-1 and latch method.
- If 2 <= len <= MAX_PAYLOAD+1: go to PAYLOAD.
- If len <= 1: frame_err pulses next cycle, FSM stays in IDLE, nothing is emitted.
- If len > MAX_PAYLOAD+1: frame_err pulses next cycle, FSM goes to DRAIN.
REQ-019 In PAYLOAD, EN_ind_deq SHALL be ind_rdy && (!out_valid || out_ready), which gives full throughput with no bubbles.
REQ-020 A word popped in PAYLOAD SHALL be registered into out_* on the same edge, so it is visible on out_* one cycle after the pop.
- out_last is set when remaining == 1.
- remaining decrements by 1.
- At remaining == 1 the FSM returns to IDLE.
REQ-021 The out_* fields SHALL remain stable while out_valid && !out_ready.
REQ-022 out_valid SHALL clear after a transfer unless a new word is loaded on the same edge.
REQ-023 In DRAIN, EN_ind_deq SHALL equal ind_rdy.
- Popped words are discarded and remaining decrements.
- At remaining == 1 the FSM returns to IDLE.
- out_valid is unaffected by DRAIN.
REQ-024 msg_count SHALL increment on each transfer with out_last high.
REQ-025 EN_ind_deq SHALL never be high while ind_rdy is low.
REQ-026 The remaining counter SHALL be 16 bits; underflow is unreachable by construction.

Configuration
REQ-027 When CNOC_DEFRAME_ERRCNT_EN is defined, err_count SHALL increment on each frame_err pulse and saturate at 0xFF.
REQ-028 When CNOC_DEFRAME_ERRCNT_EN is undefined, err_count SHALL be tied to 0 and its counter logic SHALL not be built; frame_err still operates.

Reset
REQ-029 While RST_N is low, the block SHALL immediately set:
- FSM to IDLE and remaining to 0;
- out_valid, out_last and frame_err to 0;
- out_data to 0 and out_method to 0;
- msg_count and err_count to 0.
REQ-030 Reset mid-message SHALL abandon the message; after release, the next upstream word is treated as a header.

Structure
REQ-031 A shared package cnoc_pkg SHALL hold:
- the header field bit positions and widths;
- the FSM state enum;
- the header type shared with the indication serializer.
REQ-032 The one-entry output stage SHALL be a sub-module cnoc_out_reg (data, method, last, valid/ready).
REQ-033 The FSM, counters and error logic SHALL reside in cnoc_ind_deframer.

Verification
REQ-034 Nominal message: header 0x0003_0003, then 0xA, 0xB, with out_ready held high.
- Required: out_* shows (0xA, method 3, last 0) then (0xB, method 3, last 1) on consecutive cycles.
- Required: msg_count becomes 1.
REQ-035 Backpressure: out_ready low for 5 cycles during a 4-payload message.
- Required: out_* is held stable and EN_ind_deq stays low while stalled.
- Required: all 4 words are delivered in order and no word is lost.
REQ-036 Zero-length header 0x0001_0001.
- Required: frame_err pulses once and no output is produced.
- Required: the next header is parsed normally.
- Required: err_count becomes 1 only when CNOC_DEFRAME_ERRCNT_EN is defined.
REQ-037 Oversize header len=20 with MAX_PAYLOAD=16.
- Required: frame_err pulses and 19 words are drained with out_valid low throughout.
- Required: the following len=2 message is delivered correctly.
REQ-038 Back-to-back messages with ind_rdy held high and out_ready high.
- Required: one header-pop cycle per message and no idle cycles between payload words.
REQ-039 Assert RST_N low mid-payload.
- Required: all outputs go to 0 immediately.
- Required: after release, the first upstream word is parsed as a header.
